// File: rtl/btn_pkg.sv
// Shared types and default constants for the button debouncer.
`timescale 1ps/1ps
package btn_pkg;

  typedef enum logic [1:0] {
    Idle,
    PressWait,
    Pressed,
    ReleaseWait
  } btn_state_e;

  localparam int unsigned DefSyncStages  = 2;
  localparam int unsigned DefDebounceCnt = 27000;
  localparam int unsigned DefLongCnt     = 2700000;

endpackage

// File: rtl/btn_sync.sv
// Multi-flop synchronizer with asynchronous reset to 1.
`timescale 1ps/1ps
module btn_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge CLK_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Debounced active-low button with press/release pulses.
// Optional long-press pulse enabled by defining DEBOUNCE_LONG_EN.
`timescale 1ps/1ps
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DefSyncStages,
  parameter int unsigned DEBOUNCE_CNT = DefDebounceCnt,
  parameter int unsigned LONG_CNT     = DefLongCnt
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic iExtBtn,
  output logic oBtnLevel,
  output logic oPressPulse,
  output logic oReleasePulse
`ifdef DEBOUNCE_LONG_EN
  ,
  output logic oLongPress
`endif
);

  localparam int unsigned CntW = $clog2(LONG_CNT + 1);
  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CNT - 1);
  localparam logic [CntW-1:0] CntMax  = '1;
`ifdef DEBOUNCE_LONG_EN
  localparam logic [CntW-1:0] LongLast = CntW'(LONG_CNT - 1);
`endif

  logic rst_hold, rst_int_n, btn_s;

  // Input flops reset straight from RESETn so they are already primed with the
  // button level when the FSM leaves its synchronized reset two clocks later.
  btn_sync #(
    .SYNC_STAGES(2)
  ) u_rst_sync (
    .CLK_i (CLK),
    .rst_ni(RESETn),
    .d_i   (1'b0),
    .q_o   (rst_hold)
  );

  assign rst_int_n = ~rst_hold;

  btn_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn_sync (
    .CLK_i (CLK),
    .rst_ni(RESETn),
    .d_i   (iExtBtn),
    .q_o   (btn_s)
  );

  btn_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic press_q, press_d, release_q, release_d;
`ifdef DEBOUNCE_LONG_EN
  logic long_q, long_d, long_done_q, long_done_d;
`endif

  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= Idle;
      cnt_q       <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
`ifdef DEBOUNCE_LONG_EN
      long_q      <= 1'b0;
      long_done_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
`ifdef DEBOUNCE_LONG_EN
      long_q      <= long_d;
      long_done_q <= long_done_d;
`endif
    end
  end

  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef DEBOUNCE_LONG_EN
    long_d      = 1'b0;
    long_done_d = long_done_q;
`endif
    unique case (state_q)
      Idle: begin
        if (!btn_s) begin
          state_d = PressWait;
          cnt_d   = '0;
        end
      end
      PressWait: begin
        if (btn_s) begin
          state_d = Idle;
        end else if (cnt_q == DebLast) begin
          state_d = Pressed;
          cnt_d   = '0;
          press_d = 1'b1;
`ifdef DEBOUNCE_LONG_EN
          long_done_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      Pressed: begin
        if (btn_s) begin
          state_d = ReleaseWait;
          cnt_d   = '0;
        end
`ifdef DEBOUNCE_LONG_EN
        else begin
          cnt_d = cnt_inc;
          // Done flag keeps a bounce back from ReleaseWait from firing twice.
          if (cnt_q == LongLast && !long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end
        end
`endif
      end
      ReleaseWait: begin
        if (!btn_s) begin
          state_d = Pressed;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d   = Idle;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = Idle;
    endcase
  end

  assign oBtnLevel     = (state_q == Pressed) || (state_q == ReleaseWait);
  assign oPressPulse   = press_q;
  assign oReleasePulse = release_q;
`ifdef DEBOUNCE_LONG_EN
  assign oLongPress    = long_q;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce (SYNC_STAGES=2, DEBOUNCE_CNT=16, LONG_CNT=64).
`timescale 1ps/1ps
module tb_btn_debounce;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  logic iExtBtn = 1'b1;
  logic oBtnLevel, oPressPulse, oReleasePulse;
`ifdef DEBOUNCE_LONG_EN
  logic oLongPress;
`endif

  btn_debounce #(
    .SYNC_STAGES (2),
    .DEBOUNCE_CNT(16),
    .LONG_CNT    (64)
  ) dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .iExtBtn      (iExtBtn),
    .oBtnLevel    (oBtnLevel),
    .oPressPulse  (oPressPulse),
    .oReleasePulse(oReleasePulse)
`ifdef DEBOUNCE_LONG_EN
    ,
    .oLongPress   (oLongPress)
`endif
  );

  initial begin
    forever begin
      #185188 CLK = 1'b1;
      #185189 CLK = 1'b0;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int press_cnt = 0;
  int release_cnt = 0;
  int both_cnt = 0;
  int long_cnt = 0;

  always @(negedge CLK) begin
    if (oPressPulse === 1'b1) press_cnt++;
    if (oReleasePulse === 1'b1) release_cnt++;
    if (oPressPulse === 1'b1 && oReleasePulse === 1'b1) both_cnt++;
`ifdef DEBOUNCE_LONG_EN
    if (oLongPress === 1'b1) long_cnt++;
`endif
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // sel: 0 press, 1 release, 2 long; lat = -1 if the pulse never shows.
  task automatic wait_pulse(input int sel, input int max, output int lat);
    logic p;
    lat = -1;
    for (int c = 1; c <= max; c++) begin
      @(negedge CLK);
      p = (sel == 0) ? oPressPulse : (sel == 1) ? oReleasePulse : 1'b0;
`ifdef DEBOUNCE_LONG_EN
      if (sel == 2) p = oLongPress;
`endif
      if (p === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  int lat, bp, br, bl;

  initial begin
    // Reset, button released
    tick(10);
    check("rst_level", int'(oBtnLevel), 0);
    check("rst_press", int'(oPressPulse), 0);
    check("rst_release", int'(oReleasePulse), 0);
    RESETn = 1'b1;
    tick(200);
    check("idle_press_cnt", press_cnt, 0);
    check("idle_release_cnt", release_cnt, 0);
    check("idle_level", int'(oBtnLevel), 0);

    // Clean press held 100 clocks
    bp = press_cnt;
    iExtBtn = 1'b0;
    wait_pulse(0, 40, lat);
    check("press_latency", lat, 19);
    check("press_level", int'(oBtnLevel), 1);
    tick(81);
    check("press_level_held", int'(oBtnLevel), 1);
    check("press_count", press_cnt - bp, 1);

    // Clean release held 100 clocks
    bp = press_cnt;
    br = release_cnt;
    iExtBtn = 1'b1;
    wait_pulse(1, 40, lat);
    check("release_latency", lat, 19);
    check("release_level", int'(oBtnLevel), 0);
    tick(81);
    check("release_count", release_cnt - br, 1);
    check("release_no_press", press_cnt - bp, 0);

    // Bounce every 5 clocks for 60 clocks, then settle pressed
    bp = press_cnt;
    for (int i = 0; i < 12; i++) begin
      iExtBtn = (i % 2 == 1);
      tick(5);
    end
    check("bounce_no_press", press_cnt - bp, 0);
    check("bounce_level", int'(oBtnLevel), 0);
    iExtBtn = 1'b0;
    wait_pulse(0, 40, lat);
    check("bounce_press_latency", lat, 19);
    tick(81);
    check("bounce_press_count", press_cnt - bp, 1);

    // Release with an 8-clock low glitch inside the release wait
    bp = press_cnt;
    br = release_cnt;
    iExtBtn = 1'b1;
    tick(10);
    iExtBtn = 1'b0;
    tick(8);
    check("glitch_level", int'(oBtnLevel), 1);
    check("glitch_no_release", release_cnt - br, 0);
    iExtBtn = 1'b1;
    wait_pulse(1, 40, lat);
    check("glitch_release_latency", lat, 19);
    tick(5);
    check("glitch_release_count", release_cnt - br, 1);
    check("glitch_no_press", press_cnt - bp, 0);

    // Reset while pressed, button still held across reset
    bp = press_cnt;
    br = release_cnt;
    iExtBtn = 1'b0;
    wait_pulse(0, 40, lat);
    check("pre_reset_press_latency", lat, 19);
    tick(20);
    RESETn = 1'b0;
    #1;
    check("reset_async_level", int'(oBtnLevel), 0);
    check("reset_async_press", int'(oPressPulse), 0);
    tick(5);
    RESETn = 1'b1;
    wait_pulse(0, 40, lat);
    check("reset_repress_latency", lat, 19);
    tick(5);
    check("reset_no_release", release_cnt - br, 0);
    check("reset_press_count", press_cnt - bp, 2);

`ifdef DEBOUNCE_LONG_EN
    // Long press: one pulse 64 clocks after the press pulse
    iExtBtn = 1'b1;
    tick(40);
    bl = long_cnt;
    iExtBtn = 1'b0;
    wait_pulse(0, 40, lat);
    check("long_press_latency", lat, 19);
    wait_pulse(2, 100, lat);
    check("long_latency", lat, 64);
    tick(120);
    check("long_count", long_cnt - bl, 1);
`endif

    check("never_both_pulses", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops (legal 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 27000, clocks of stable input required to accept a level change (about 10 ms at 2.7 MHz; legal >= 2).
REQ-003 SHALL have parameter LONG_CNT, default 2700000, clocks held pressed before a long-press event (legal > DEBOUNCE_CNT).
REQ-004 SHALL have port CLK, input, 1, single system clock, rising-edge.
REQ-005 SHALL have port RESETn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port iExtBtn, input, 1, raw asynchronous button, active-low (0 = pressed).
REQ-007 SHALL have port oBtnLevel, output, 1, debounced level, active-high (1 = pressed).
REQ-008 SHALL have port oPressPulse, output, 1, one-clock pulse per accepted press; feeds the downstream one-shot blink stage.
REQ-009 SHALL have port oReleasePulse, output, 1, one-clock pulse per accepted release.
REQ-010 SHALL have port oLongPress, output, 1, one-clock pulse; present only with DEBOUNCE_LONG_EN (REQ-026).

Function
REQ-011 SHALL pass iExtBtn through SYNC_STAGES flops, reset value 1 (released), before any other logic uses it.
REQ-012 SHALL implement FSM states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 IDLE: synchronized input 0 -> PRESS_WAIT, counter cleared to 0.
REQ-014 PRESS_WAIT: input 1 -> IDLE (bounce rejected); else counter increments; at counter = DEBOUNCE_CNT-1 -> PRESSED.
REQ-015 PRESSED: input 1 -> RELEASE_WAIT, counter cleared to 0.
REQ-016 RELEASE_WAIT: input 0 -> PRESSED (bounce rejected, no pulses); else counter increments; at DEBOUNCE_CNT-1 -> IDLE.
REQ-017 oBtnLevel SHALL be 1 exactly in PRESSED and RELEASE_WAIT.
REQ-018 oPressPulse SHALL be registered, high for exactly the first cycle in PRESSED entered from PRESS_WAIT; oReleasePulse likewise for the first cycle in IDLE entered from RELEASE_WAIT.
REQ-019 Latency: a clean press held constant SHALL produce oPressPulse exactly SYNC_STAGES + DEBOUNCE_CNT + 1 clocks after the first CLK edge sampling iExtBtn = 0; release identical.
REQ-020 A glitch shorter than DEBOUNCE_CNT stable clocks SHALL produce no pulse and no oBtnLevel change.
REQ-021 Counter width SHALL be $clog2(LONG_CNT+1) bits and SHALL saturate, never wrap.
REQ-022 oPressPulse and oReleasePulse SHALL never be high in the same cycle; at most one of the two per accepted transition.

Reset
REQ-023 RESETn low SHALL asynchronously force state IDLE, counter 0, synchronizer flops 1, all outputs 0.
REQ-024 Reset deassertion SHALL be synchronized internally (2-flop release); a button already held at release SHALL yield one oPressPulse after REQ-019 latency.
REQ-025 Reset mid-PRESS_WAIT or mid-PRESSED SHALL emit no oReleasePulse.

Configuration
REQ-026 Macro DEBOUNCE_LONG_EN defined: counter keeps running in PRESSED; oLongPress pulses one clock when held LONG_CNT clocks after entering PRESSED, at most once per press; counter clears on RELEASE_WAIT exit to PRESSED. Undefined: oLongPress port and long-press logic absent, counter idle in PRESSED.

Structure
REQ-027 Package btn_pkg SHALL hold the FSM state enum and default constants (SYNC_STAGES, DEBOUNCE_CNT, LONG_CNT).
REQ-028 Synchronizer SHALL be sub-module btn_sync (parameter SYNC_STAGES, reset value 1), reused for the reset-release synchronizer.

Verification (bench: SYNC_STAGES=2, DEBOUNCE_CNT=16, LONG_CNT=64, CLK period 370377 ps)
REQ-029 Reset 10 clocks, iExtBtn=1 -> all outputs 0, no pulses for 200 clocks.
REQ-030 iExtBtn 1->0 held 100 clocks -> one oPressPulse exactly 19 clocks after first 0 sample; oBtnLevel 1 from that cycle on.
REQ-031 Bounces 0/1 every 5 clocks for 60 clocks, then 0 held -> no pulse during bounce; exactly one oPressPulse 19 clocks after final settling.
REQ-032 Pressed 100 clocks then release held 100 clocks -> one oReleasePulse 19 clocks after first 1 sample; one 8-clock 0 glitch during release wait -> release delayed, no extra oPressPulse.
REQ-033 RESETn pulsed low during PRESSED -> outputs 0 immediately, no oReleasePulse, re-press pulse after 19 clocks from reset release if button still held.
REQ-034 With DEBOUNCE_LONG_EN, hold 200 clocks -> oLongPress exactly once, 64 clocks after oPressPulse; without macro, build has no oLongPress port.
